// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding and its width.
package pulse_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StGap  = 2'd2
  } state_e;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter that saturates at zero. Load wins over enable.
module load_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Stretches a one-cycle tick into a len-cycle pulse followed by a guaranteed
// low gap of MIN_LOW cycles. One counter is shared between the pulse and gap.
module pulse_stretch
  import pulse_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned MIN_LOW = 2,
  parameter int unsigned RETRIG  = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tick,
  input  logic [W-1:0] len,
  output logic         level,
  output logic         busy,
  output logic         done,
  output logic         drop
);

  localparam logic [W-1:0] GapLoad = W'(MIN_LOW - 1);

  state_e       state_q;
  logic         level_q, done_q, drop_q;
  logic         accept, reload, hold_end, gap_end, drop_ev;
  logic         cnt_load, cnt_en, cnt_zero;
  logic [W-1:0] cnt_val;

  always_comb begin
    accept   = (state_q == StIdle) && tick && (len != '0);
    reload   = (RETRIG != 0) && (state_q == StHold) && tick && (len != '0);
    hold_end = (state_q == StHold) && !reload && cnt_zero;
    gap_end  = (state_q == StGap) && cnt_zero;
    // Ticks are dropped in GAP and in HOLD unless they retrigger the pulse.
    drop_ev  = tick && (((state_q == StHold) && !reload) || (state_q == StGap));
    cnt_load = accept || reload || hold_end;
    cnt_val  = hold_end ? GapLoad : (len - W'(1));
    cnt_en   = (state_q != StIdle);
  end

  load_down_counter #(
    .W(W)
  ) u_counter (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      level_q <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle:  if (accept)   state_q <= StHold;
        StHold:  if (hold_end) state_q <= StGap;
        StGap:   if (gap_end)  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      level_q <= accept || ((state_q == StHold) && !hold_end);
      done_q  <= hold_end;
      drop_q  <= drop_ev;
    end
  end

  assign level = level_q;
  assign busy  = (state_q != StIdle);
  assign done  = done_q;
  assign drop  = drop_q;

endmodule
